// File: rtl/pipe_stage_ctrl_pkg.sv
// Shared constants for pipeline top-levels: stage indices and controller defaults.
package pipe_stage_ctrl_pkg;

  localparam int unsigned NUM_STAGES_DEF = 4;
  localparam int unsigned CNT_W_DEF      = 16;

  typedef enum logic [2:0] {
    STG_IF = 3'd0,
    STG_ID = 3'd1,
    STG_EX = 3'd2,
    STG_WB = 3'd3
  } stage_e;

endpackage

// File: rtl/pipe_stage_ctrl_if.sv
// Issue/retire handshake plus per-stage stall/squash/enable bundle of the pipeline controller.
interface pipe_stage_ctrl_if
  import pipe_stage_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = NUM_STAGES_DEF
);

  logic                  in_valid;
  logic                  in_ready;
  logic [NUM_STAGES-1:0] stall_req;
  logic [NUM_STAGES-1:0] squash_req;
  logic                  out_ready;
  logic                  out_valid;
  logic [NUM_STAGES-1:0] en;
  logic [NUM_STAGES-1:0] squashn;
  logic [NUM_STAGES-1:0] stage_valid;

  modport master (
    input  in_valid, stall_req, squash_req, out_ready,
    output in_ready, out_valid, en, squashn, stage_valid
  );

  modport slave (
    output in_valid, stall_req, squash_req, out_ready,
    input  in_ready, out_valid, en, squashn, stage_valid
  );

endinterface

// File: rtl/pipe_stage_ctrl_cnt.sv
// Saturating event counter with synchronous clear (clear wins over increment).
module pipe_stage_ctrl_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Pipeline controller: per-stage valids, backward stall chain with bubble absorption,
// squash-to-clear translation and a stall-cycle counter.
module pipe_stage_ctrl
  import pipe_stage_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  pipe_stage_ctrl_if.master ctl,
  input  logic              stall_cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [NUM_STAGES-1:0] v;
  logic [NUM_STAGES-1:0] stalled;
  logic [NUM_STAGES-1:0] kill;
  logic [NUM_STAGES-1:0] en;
  logic [NUM_STAGES-1:0] v_in;
  logic [NUM_STAGES-1:0] squashn_c;
  logic                  blk;
  logic                  sq_above;
  logic                  any_sq;
  logic                  in_rdy;

  // Walk oldest to youngest: blk carries "downstream cannot take", sq_above carries
  // "an older stage resolved a redirect", so stage k itself only dies if it moves.
  always_comb begin
    stalled  = '0;
    kill     = '0;
    blk      = ~ctl.out_ready;
    sq_above = 1'b0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      blk = v[NUM_STAGES-1-k] & (ctl.stall_req[NUM_STAGES-1-k] | blk);
      stalled[NUM_STAGES-1-k] = blk;
      kill[NUM_STAGES-1-k]    = sq_above | (ctl.squash_req[NUM_STAGES-1-k] & ~blk);
      sq_above                = sq_above | ctl.squash_req[NUM_STAGES-1-k];
    end
  end

  assign en     = ~stalled;
  assign any_sq = |ctl.squash_req;
  assign in_rdy = en[0] & ~any_sq;

  // Valid presented at the input of each stage register; a zero here is a bubble.
  assign v_in      = {v[NUM_STAGES-2:0] & ~ctl.stall_req[NUM_STAGES-2:0], ctl.in_valid & in_rdy};
  assign squashn_c = ~(kill | (en & ~v_in));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v <= '0;
    end else begin
      v <= ~kill & ((en & v_in) | (~en & v));
    end
  end

  assign ctl.en          = en;
  assign ctl.in_ready    = in_rdy;
  assign ctl.out_valid   = v[NUM_STAGES-1] & ~ctl.stall_req[NUM_STAGES-1];
  assign ctl.stage_valid = v;
  // Registers are already cleared by reset, so no bubble clears are driven meanwhile.
  assign ctl.squashn     = resetn ? squashn_c : '1;

  pipe_stage_ctrl_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (stall_cnt_clr),
    .inc    (ctl.in_valid & ~in_rdy),
    .cnt    (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Bench for pipe_stage_ctrl: directed scenarios plus random traffic against an
// instruction-slot reference model of the pipeline.
module tb_pipe_stage_ctrl;
  import pipe_stage_ctrl_pkg::*;

  localparam int unsigned NS  = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned CW2 = 4;

  logic           clk = 1'b0;
  logic           resetn;
  logic           clr;
  logic           clr2;
  logic [CW-1:0]  cnt;
  logic [CW2-1:0] cnt2;

  pipe_stage_ctrl_if #(.NUM_STAGES(NS)) bus ();
  pipe_stage_ctrl_if #(.NUM_STAGES(NS)) bus2 ();

  pipe_stage_ctrl #(.NUM_STAGES(NS), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .ctl(bus), .stall_cnt_clr(clr), .stall_cnt(cnt)
  );

  pipe_stage_ctrl #(.NUM_STAGES(NS), .CNT_W(CW2)) dut_sat (
    .clk(clk), .resetn(resetn), .ctl(bus2), .stall_cnt_clr(clr2), .stall_cnt(cnt2)
  );

  always #5 clk = ~clk;

  // Reference model: each slot holds an instruction id, 0 = empty.
  int unsigned    pipe [NS];
  int unsigned    nxt  [NS];
  int unsigned    next_id;
  logic [CW-1:0]  m_cnt;
  logic [NS-1:0]  e_en, e_sqn, e_sv;
  logic           e_inr, e_outv, m_issue, m_retire;
  int unsigned    m_retired, d_retired;
  int             n_tests, n_fail;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) pipe[i] = 0;
    m_cnt = '0;
  endtask

  task automatic model_eval();
    logic        acc [NS];
    logic        lv  [NS];
    logic        killed;
    logic        dst_free;
    int unsigned inc_id;
    for (int i = NS - 1; i >= 0; i--) begin
      if (i == NS - 1) dst_free = bus.out_ready;
      else             dst_free = acc[i+1];
      lv[i]  = (pipe[i] != 0) && !bus.stall_req[i] && dst_free;
      acc[i] = (pipe[i] == 0) || lv[i];
    end
    e_inr    = acc[0] && (bus.squash_req == '0);
    e_outv   = (pipe[NS-1] != 0) && !bus.stall_req[NS-1];
    m_issue  = bus.in_valid && e_inr;
    m_retire = e_outv && bus.out_ready;
    for (int i = 0; i < NS; i++) begin
      killed = 1'b0;
      for (int k = i; k < NS; k++)
        if (bus.squash_req[k] && (k > i || acc[i])) killed = 1'b1;
      if (i == 0) inc_id = m_issue ? next_id : 0;
      else        inc_id = lv[i-1] ? pipe[i-1] : 0;
      nxt[i]   = killed ? 0 : (acc[i] ? inc_id : pipe[i]);
      e_en[i]  = acc[i];
      e_sqn[i] = !(killed || (acc[i] && inc_id == 0));
      e_sv[i]  = pipe[i] != 0;
    end
  endtask

  task automatic model_commit();
    for (int i = 0; i < NS; i++) pipe[i] = nxt[i];
    if (m_issue)  next_id++;
    if (m_retire) m_retired++;
    if (clr) m_cnt = '0;
    else if (bus.in_valid && !e_inr && m_cnt != '1) m_cnt = m_cnt + 1'b1;
  endtask

  task automatic drive(input logic iv, input logic [NS-1:0] sr, input logic [NS-1:0] sq,
                       input logic ordy, input logic c);
    bus.in_valid   = iv;
    bus.stall_req  = sr;
    bus.squash_req = sq;
    bus.out_ready  = ordy;
    clr            = c;
    #2;
    model_eval();
  endtask

  task automatic tick();
    if (bus.out_valid && bus.out_ready) d_retired++;
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      tick();
    end
  endtask

  task automatic fill();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, '0, '0, 1'b1, 1'b0);
      tick();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.in_valid = 1'b0; bus.stall_req = '0; bus.squash_req = '0; bus.out_ready = 1'b1;
    clr = 1'b0;
    #3;
    n_tests++; if (bus.en !== 4'b1111) begin n_fail++; $display("FAIL reset_en: got %b, expected 1111", bus.en); end
    n_tests++; if (bus.squashn !== 4'b1111) begin n_fail++; $display("FAIL reset_squashn: got %b, expected 1111", bus.squashn); end
    n_tests++; if (bus.stage_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_stage_valid: got %b, expected 0000", bus.stage_valid); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
    n_tests++; if (cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d, expected 0", cnt); end
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    int          first = -1;
    int unsigned start = d_retired;
    for (int c = 0; c < 14; c++) begin
      drive(c < 6, '0, '0, 1'b1, 1'b0);
      n_tests++; if (bus.en !== 4'b1111) begin n_fail++; $display("FAIL stream_en c%0d: got %b, expected 1111", c, bus.en); end
      n_tests++; if (bus.out_valid !== e_outv) begin n_fail++; $display("FAIL stream_out_valid c%0d: got %b, expected %b", c, bus.out_valid, e_outv); end
      if (bus.out_valid && first < 0) first = c;
      tick();
    end
    n_tests++; if (first !== 4) begin n_fail++; $display("FAIL stream_latency: got %0d, expected 4", first); end
    n_tests++; if (d_retired - start !== 6) begin n_fail++; $display("FAIL stream_retires: got %0d, expected 6", d_retired - start); end
  endtask

  task automatic test_backpressure();
    int unsigned start = d_retired;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, '0, '0, 1'b0, 1'b1);
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, '0, '0, 1'b0, 1'b0);
      n_tests++; if (bus.en !== 4'b0000) begin n_fail++; $display("FAIL bp_en c%0d: got %b, expected 0000", c, bus.en); end
      n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b, expected 0", c, bus.in_ready); end
      tick();
    end
    n_tests++; if (cnt !== 3) begin n_fail++; $display("FAIL bp_stall_cnt: got %0d, expected 3", cnt); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release_out_valid: got %b, expected 1", bus.out_valid); end
    n_tests++; if (bus.en !== 4'b1111) begin n_fail++; $display("FAIL bp_release_en: got %b, expected 1111", bus.en); end
    tick();
    drain();
    n_tests++; if (d_retired - start !== 4) begin n_fail++; $display("FAIL bp_retires: got %0d, expected 4", d_retired - start); end
  endtask

  task automatic test_bubble();
    drive(1'b1, '0, '0, 1'b1, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0); tick();
    drive(1'b1, '0, '0, 1'b1, 1'b0); tick();
    n_tests++; if (bus.stage_valid !== 4'b0101) begin n_fail++; $display("FAIL bubble_setup: got %b, expected 0101", bus.stage_valid); end
    drive(1'b0, 4'b0100, '0, 1'b1, 1'b0);
    n_tests++; if (bus.en !== 4'b1011) begin n_fail++; $display("FAIL bubble_en: got %b, expected 1011", bus.en); end
    n_tests++; if (bus.squashn !== e_sqn) begin n_fail++; $display("FAIL bubble_squashn: got %b, expected %b", bus.squashn, e_sqn); end
    tick();
    n_tests++; if (bus.stage_valid !== 4'b0110) begin n_fail++; $display("FAIL bubble_advance: got %b, expected 0110", bus.stage_valid); end
    drain();
  endtask

  task automatic test_squash_moving();
    fill();
    n_tests++; if (bus.stage_valid !== 4'b1111) begin n_fail++; $display("FAIL sqm_full: got %b, expected 1111", bus.stage_valid); end
    drive(1'b1, '0, 4'b0100, 1'b1, 1'b0);
    n_tests++; if (bus.squashn !== 4'b1000) begin n_fail++; $display("FAIL sqm_squashn: got %b, expected 1000", bus.squashn); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL sqm_in_ready: got %b, expected 0", bus.in_ready); end
    tick();
    n_tests++; if (bus.stage_valid !== 4'b1000) begin n_fail++; $display("FAIL sqm_valid: got %b, expected 1000", bus.stage_valid); end
    drain();
  endtask

  task automatic test_squash_stalled();
    logic [NS-1:0] sq = 4'b0100;
    fill();
    drive(1'b1, sq, sq, 1'b1, 1'b0);
    n_tests++; if (bus.squashn[2] !== 1'b1) begin n_fail++; $display("FAIL sqs_resolver_holds: got %b, expected 1", bus.squashn[2]); end
    n_tests++; if (bus.squashn[1:0] !== 2'b00) begin n_fail++; $display("FAIL sqs_younger_killed: got %b, expected 00", bus.squashn[1:0]); end
    n_tests++; if (bus.squashn !== e_sqn) begin n_fail++; $display("FAIL sqs_squashn: got %b, expected %b", bus.squashn, e_sqn); end
    tick();
    n_tests++; if (bus.stage_valid !== 4'b0100) begin n_fail++; $display("FAIL sqs_valid: got %b, expected 0100", bus.stage_valid); end
    drain();
  endtask

  task automatic test_random();
    logic [NS-1:0] sr, sq;
    int unsigned   d0 = d_retired;
    int unsigned   m0 = m_retired;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < NS; b++) sr[b] = ($urandom_range(0, 7) == 0);
      sq = '0;
      if ($urandom_range(0, 14) == 0) sq[$urandom_range(0, NS - 1)] = 1'b1;
      if ($urandom_range(0, 59) == 0) sq[$urandom_range(0, NS - 1)] = 1'b1;
      drive($urandom_range(0, 3) != 0, sr, sq, $urandom_range(0, 4) != 0, $urandom_range(0, 49) == 0);
      n_tests++; if (bus.en !== e_en) begin n_fail++; $display("FAIL rnd_en c%0d: got %b, expected %b", c, bus.en, e_en); end
      n_tests++; if (bus.squashn !== e_sqn) begin n_fail++; $display("FAIL rnd_squashn c%0d: got %b, expected %b", c, bus.squashn, e_sqn); end
      n_tests++; if (bus.in_ready !== e_inr) begin n_fail++; $display("FAIL rnd_in_ready c%0d: got %b, expected %b", c, bus.in_ready, e_inr); end
      n_tests++; if (bus.out_valid !== e_outv) begin n_fail++; $display("FAIL rnd_out_valid c%0d: got %b, expected %b", c, bus.out_valid, e_outv); end
      n_tests++; if (bus.stage_valid !== e_sv) begin n_fail++; $display("FAIL rnd_stage_valid c%0d: got %b, expected %b", c, bus.stage_valid, e_sv); end
      n_tests++; if (cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_stall_cnt c%0d: got %0d, expected %0d", c, cnt, m_cnt); end
      tick();
    end
    drain();
    n_tests++; if (d_retired - d0 !== m_retired - m0) begin n_fail++; $display("FAIL rnd_retire_count: got %0d, expected %0d", d_retired - d0, m_retired - m0); end
  endtask

  task automatic test_async_reset();
    fill();
    drive(1'b1, '0, '0, 1'b0, 1'b0); tick();
    drive(1'b1, '0, '0, 1'b0, 1'b0); tick();
    n_tests++; if (cnt !== m_cnt) begin n_fail++; $display("FAIL ar_pre_cnt: got %0d, expected %0d", cnt, m_cnt); end
    #2;
    resetn = 1'b0;
    #1;
    n_tests++; if (bus.stage_valid !== 4'b0000) begin n_fail++; $display("FAIL ar_stage_valid: got %b, expected 0000", bus.stage_valid); end
    n_tests++; if (cnt !== '0) begin n_fail++; $display("FAIL ar_stall_cnt: got %0d, expected 0", cnt); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_out_valid: got %b, expected 0", bus.out_valid); end
    n_tests++; if (bus.squashn !== 4'b1111) begin n_fail++; $display("FAIL ar_squashn: got %b, expected 1111", bus.squashn); end
    model_reset();
    bus.in_valid = 1'b0; bus.stall_req = '0; bus.squash_req = '0; bus.out_ready = 1'b1;
    clr = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturation();
    int unsigned exp;
    clr2 = 1'b1;
    @(posedge clk);
    #1;
    clr2 = 1'b0;
    n_tests++; if (cnt2 !== 4'd0) begin n_fail++; $display("FAIL sat_clr_priority: got %0d, expected 0", cnt2); end
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      exp = (k > 15) ? 15 : k;
      n_tests++; if (cnt2 !== exp[CW2-1:0]) begin n_fail++; $display("FAIL sat_count k%0d: got %0d, expected %0d", k, cnt2, exp); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    n_tests = 0; n_fail = 0;
    next_id = 1; m_retired = 0; d_retired = 0;
    clr2 = 1'b0;
    bus2.in_valid = 1'b1; bus2.stall_req = '0; bus2.squash_req = 4'b0001; bus2.out_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_squash_moving();
    test_squash_stalled();
    test_random();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
